// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the fetch/execute slice.
// Holds the PC width, the canonical NOP and the fetch FSM encoding.
package core_pkg;

  localparam int PC_W = 8;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetchState_t;

  typedef struct packed {
    logic [31:0]     ir;
    logic [PC_W-1:0] pc;
  } ifId_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem handshake, redirect and decode-side bundle.
// master is the fetch stage, slave is memory plus the execute side.
interface instruction_fetch_if #(
  parameter int PC_W = 8
);

  logic            oIMEM_REQ;
  logic [PC_W-1:0] oIMEM_ADDR;
  logic            iIMEM_ACK;
  logic [31:0]     iIMEM_DATA;
  logic            iBRANCH_TAKEN;
  logic [PC_W-1:0] iBRANCH_TARGET;
  logic            iSTALL;
  logic            oVALID;
  logic [31:0]     oIR;
  logic [PC_W-1:0] oPC;

  modport master (
    output oIMEM_REQ,
    output oIMEM_ADDR,
    input  iIMEM_ACK,
    input  iIMEM_DATA,
    input  iBRANCH_TAKEN,
    input  iBRANCH_TARGET,
    input  iSTALL,
    output oVALID,
    output oIR,
    output oPC
  );

  modport slave (
    input  oIMEM_REQ,
    input  oIMEM_ADDR,
    output iIMEM_ACK,
    output iIMEM_DATA,
    output iBRANCH_TAKEN,
    output iBRANCH_TARGET,
    output iSTALL,
    input  oVALID,
    input  oIR,
    input  oPC
  );

endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the byte PC and fetches words over REQ/ACK.
// Holds {oIR,oPC} until accepted; redirects squash in-flight fetches.
module instruction_fetch
  import core_pkg::*;
#(
  parameter int              PC_W     = core_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0]     NOP      = NOP_INSTR
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  instruction_fetch_if.master bus
);

  fetchState_t state;
  fetchState_t stateNext;

  logic            req;
  logic            reqNext;
  logic [PC_W-1:0] addr;
  logic [PC_W-1:0] addrNext;
  logic            valid;
  logic            validNext;
  logic [31:0]     ir;
  logic [31:0]     irNext;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pcNext;
  logic [PC_W-1:0] pend;
  logic [PC_W-1:0] pendNext;

  logic            branch;
  logic            ack;
  logic            stall;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] seqPc;

  assign branch = bus.iBRANCH_TAKEN;
  assign ack    = bus.iIMEM_ACK;
  assign stall  = bus.iSTALL;
  assign target = bus.iBRANCH_TARGET & ~PC_W'(3);
  assign seqPc  = pc + PC_W'(4);

  // Next state and next register values; every path starts from a hold.
  always_comb begin
    stateNext = state;
    reqNext   = req;
    addrNext  = addr;
    validNext = valid;
    irNext    = ir;
    pcNext    = pc;
    pendNext  = pend;
    unique case (state)
      IDLE: begin
        stateNext = FETCH;
        reqNext   = 1'b1;
        addrNext  = RESET_PC;
      end
      FETCH: begin
        unique case (1'b1)
          branch && ack: begin
            addrNext = target;
          end
          branch && !ack: begin
            pendNext  = target;
            stateNext = DROP;
          end
          !branch && ack: begin
            irNext    = bus.iIMEM_DATA;
            pcNext    = addr;
            validNext = 1'b1;
            reqNext   = 1'b0;
            stateNext = VALID;
          end
          default: ;
        endcase
      end
      VALID: begin
        unique case (1'b1)
          branch: begin
            validNext = 1'b0;
            irNext    = NOP;
            reqNext   = 1'b1;
            addrNext  = target;
            stateNext = FETCH;
          end
          !branch && !stall: begin
            validNext = 1'b0;
            irNext    = NOP;
            reqNext   = 1'b1;
            addrNext  = seqPc;
            stateNext = FETCH;
          end
          default: ;
        endcase
      end
      DROP: begin
        unique case (1'b1)
          ack: begin
            addrNext  = branch ? target : pend;
            stateNext = FETCH;
          end
          !ack && branch: begin
            pendNext = target;
          end
          default: ;
        endcase
      end
      default: begin
        stateNext = IDLE;
        reqNext   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset beats any in-flight handshake.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= IDLE;
      req   <= 1'b0;
      addr  <= RESET_PC;
      valid <= 1'b0;
      ir    <= NOP;
      pc    <= RESET_PC;
      pend  <= RESET_PC;
    end else begin
      state <= stateNext;
      req   <= reqNext;
      addr  <= addrNext;
      valid <= validNext;
      ir    <= irNext;
      pc    <= pcNext;
      pend  <= pendNext;
    end
  end

  assign bus.oIMEM_REQ  = req;
  assign bus.oIMEM_ADDR = addr;
  assign bus.oVALID     = valid;
  assign bus.oIR        = ir;
  assign bus.oPC        = pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for the fetch stage.
// Random memory latency, stalls and redirects against a PC-stream model.
module tb_instruction_fetch;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_if #(.PC_W(W)) bus0 ();
  instruction_fetch_if #(.PC_W(W)) bus1 ();

  instruction_fetch #(
    .PC_W(W), .RESET_PC(8'h00), .NOP(32'h0000_0013)
  ) u0 (
    .iCLK(clk), .iRST_N(rstN), .bus(bus0)
  );

  instruction_fetch #(
    .PC_W(W), .RESET_PC(8'hFC), .NOP(32'h0000_0013)
  ) u1 (
    .iCLK(clk), .iRST_N(rstN), .bus(bus1)
  );

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [64];
  logic [7:0]  expQ [$];
  logic [7:0]  heldPc = 8'h00;

  int lat = 0;
  bit randLat = 1'b0;
  bit toggleAck = 1'b0;
  bit spurious = 1'b0;
  bit wrapDone = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic waitValid(input string nm);
    int n = 0;
    while (!bus0.oVALID && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout waiting oVALID got 0 want 1", nm);
    end
  endtask

  // Memory model: serves REQ after a chosen latency, may toggle stray ACKs.
  initial begin : responder
    int need;
    bit gave;
    bit tog;
    need = -1;
    gave = 1'b0;
    tog = 1'b0;
    bus0.iIMEM_ACK = 1'b0;
    bus0.iIMEM_DATA = '0;
    forever begin
      @(negedge clk);
      #1;
      if (gave) need = -1;
      gave = 1'b0;
      bus0.iIMEM_ACK = 1'b0;
      bus0.iIMEM_DATA = $urandom;
      if (toggleAck) begin
        tog = ~tog;
        bus0.iIMEM_ACK = tog;
        need = -1;
      end else if (!rstN) begin
        need = -1;
      end else if (bus0.oIMEM_REQ) begin
        if (need < 0) need = randLat ? int'($urandom_range(0, 3)) : lat;
        if (need == 0) begin
          bus0.iIMEM_ACK = 1'b1;
          bus0.iIMEM_DATA = mem[bus0.oIMEM_ADDR[7:2]];
          gave = 1'b1;
        end else begin
          need--;
        end
      end else if (spurious && $urandom_range(0, 7) == 0) begin
        bus0.iIMEM_ACK = 1'b1;
      end
    end
  end

  // Reference model: next presented PC is target on redirect, else PC+4.
  always @(posedge clk) begin
    logic [7:0] nxt;
    nxt = heldPc + 8'd4;
    if (!rstN) begin
      expQ.delete();
      expQ.push_back(8'h00);
    end else if (bus0.iBRANCH_TAKEN) begin
      expQ.delete();
      expQ.push_back(bus0.iBRANCH_TARGET & 8'hFC);
    end else if (bus0.oVALID && !bus0.iSTALL) begin
      expQ.push_back(nxt);
    end
  end

  // Monitor: checks handshake rules and pops the scoreboard on each new word.
  initial begin : monitor
    logic pReq;
    logic pValid;
    logic pDrop;
    logic [7:0] pAddr;
    logic [7:0] pPc;
    logic [31:0] pIr;
    logic [7:0] e;
    logic ack;
    logic br;
    logic stall;
    pReq = 1'b0;
    pValid = 1'b0;
    pDrop = 1'b0;
    pAddr = '0;
    pPc = '0;
    pIr = '0;
    forever begin
      @(negedge clk);
      ack = bus0.iIMEM_ACK;
      br = bus0.iBRANCH_TAKEN;
      stall = bus0.iSTALL;
      if (rstN) begin
        if (pReq && !ack) begin
          chk("reqHold", bus0.oIMEM_REQ, 1);
          chk("addrHold", bus0.oIMEM_ADDR, pAddr);
        end
        if (pValid && stall && !br) begin
          chk("stallValid", bus0.oVALID, 1);
          chk("stallIr", bus0.oIR, pIr);
          chk("stallPc", bus0.oPC, pPc);
          chk("stallReq", bus0.oIMEM_REQ, 0);
        end
        if (br) chk("redirectValid", bus0.oVALID, 0);
        if (pReq && ack && !br && !pDrop)
          chk("ackLatency", bus0.oVALID, 1);
        if (!pValid && bus0.oVALID) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard: got pc %h want none", bus0.oPC);
          end else begin
            e = expQ.pop_front();
            chk("presentPc", bus0.oPC, e);
            chk("presentIr", bus0.oIR, mem[e[7:2]]);
            heldPc = e;
          end
        end
        pDrop = (pReq && !ack && br) || (pDrop && !ack);
      end else begin
        pDrop = 1'b0;
      end
      pReq = bus0.oIMEM_REQ;
      pValid = bus0.oVALID;
      pAddr = bus0.oIMEM_ADDR;
      pPc = bus0.oPC;
      pIr = bus0.oIR;
    end
  end

  // Second instance starts at 8'hFC and must wrap its next fetch to 8'h00.
  initial begin : wrapResponder
    bus1.iIMEM_ACK = 1'b0;
    bus1.iIMEM_DATA = '0;
    bus1.iBRANCH_TAKEN = 1'b0;
    bus1.iBRANCH_TARGET = '0;
    bus1.iSTALL = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus1.iIMEM_ACK = rstN && bus1.oIMEM_REQ;
      bus1.iIMEM_DATA = {24'hA0_0000, bus1.oIMEM_ADDR};
    end
  end

  initial begin : wrapCheck
    logic [7:0] seen [$];
    logic pReq;
    logic [7:0] pAddr;
    bit gotValid;
    pReq = 1'b0;
    pAddr = '0;
    gotValid = 1'b0;
    for (int c = 0; c < 60 && seen.size() < 2; c++) begin
      @(negedge clk);
      if (rstN && bus1.oIMEM_REQ && (!pReq || bus1.oIMEM_ADDR != pAddr))
        seen.push_back(bus1.oIMEM_ADDR);
      if (rstN && bus1.oVALID && !gotValid) begin
        gotValid = 1'b1;
        chk("wrapPc", bus1.oPC, 8'hFC);
        chk("wrapIr", bus1.oIR, 32'hA000_00FC);
      end
      pReq = bus1.oIMEM_REQ;
      pAddr = bus1.oIMEM_ADDR;
    end
    if (seen.size() < 2) begin
      compared++;
      mismatched++;
      $display("FAIL wrapFetch: got %0d fetches want 2", seen.size());
    end else begin
      chk("wrapFirstAddr", seen[0], 8'hFC);
      chk("wrapSecondAddr", seen[1], 8'h00);
    end
    wrapDone = 1'b1;
  end

  // Directed scenarios first, then a long randomized run.
  initial begin : stimulus
    logic [7:0] nxt;
    int n;
    foreach (mem[i]) mem[i] = $urandom;
    mem[0] = 32'h0000_0537;
    mem[1] = 32'h0000_1517;
    bus0.iBRANCH_TAKEN = 1'b0;
    bus0.iBRANCH_TARGET = '0;
    bus0.iSTALL = 1'b0;

    rstN = 1'b0;
    toggleAck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstReq", bus0.oIMEM_REQ, 0);
      chk("rstValid", bus0.oVALID, 0);
      chk("rstIr", bus0.oIR, 32'h13);
      chk("rstPc", bus0.oPC, 8'h00);
      chk("rstAddr", bus0.oIMEM_ADDR, 8'h00);
    end
    #1;
    rstN = 1'b1;
    toggleAck = 1'b0;
    lat = 0;
    @(negedge clk);
    chk("releaseReq", bus0.oIMEM_REQ, 1);
    chk("releaseAddr", bus0.oIMEM_ADDR, 8'h00);
    repeat (6) @(negedge clk);

    #1 bus0.iSTALL = 1'b1;
    waitValid("stallEntry");
    repeat (4) @(negedge clk);
    #1 bus0.iSTALL = 1'b0;
    @(negedge clk);
    nxt = heldPc + 8'd4;
    chk("stallNextReq", bus0.oIMEM_REQ, 1);
    chk("stallNextAddr", bus0.oIMEM_ADDR, nxt);

    #1 bus0.iSTALL = 1'b1;
    waitValid("dropEntry");
    lat = 3;
    #1 bus0.iSTALL = 1'b0;
    @(negedge clk);
    #1;
    bus0.iBRANCH_TAKEN = 1'b1;
    bus0.iBRANCH_TARGET = 8'h42;
    @(negedge clk);
    #1 bus0.iBRANCH_TAKEN = 1'b0;
    n = 0;
    while (bus0.oIMEM_ADDR != 8'h40 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("dropNextAddr", bus0.oIMEM_ADDR, 8'h40);
    waitValid("dropValid");
    chk("dropPc", bus0.oPC, 8'h40);

    #1 bus0.iSTALL = 1'b1;
    lat = 0;
    @(negedge clk);
    #1 bus0.iSTALL = 1'b0;
    @(negedge clk);
    #1 bus0.iSTALL = 1'b1;
    waitValid("ackBranchEntry");
    #1 bus0.iSTALL = 1'b0;
    @(negedge clk);
    #1;
    bus0.iBRANCH_TAKEN = 1'b1;
    bus0.iBRANCH_TARGET = 8'h20;
    @(negedge clk);
    chk("ackBranchAddr", bus0.oIMEM_ADDR, 8'h20);
    chk("ackBranchReq", bus0.oIMEM_REQ, 1);
    chk("ackBranchValid", bus0.oVALID, 0);
    #1;
    bus0.iBRANCH_TAKEN = 1'b0;
    bus0.iSTALL = 1'b1;
    waitValid("validBranchEntry");
    chk("ackBranchPc", bus0.oPC, 8'h20);
    #1;
    bus0.iSTALL = 1'b0;
    bus0.iBRANCH_TAKEN = 1'b1;
    bus0.iBRANCH_TARGET = 8'h30;
    @(negedge clk);
    chk("validBranchValid", bus0.oVALID, 0);
    chk("validBranchReq", bus0.oIMEM_REQ, 1);
    chk("validBranchAddr", bus0.oIMEM_ADDR, 8'h30);
    #1 bus0.iBRANCH_TAKEN = 1'b0;

    randLat = 1'b1;
    spurious = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      rstN = !(i >= 1500 && i < 1502);
      bus0.iSTALL = ($urandom_range(0, 9) < 3);
      bus0.iBRANCH_TAKEN = (bus0.oIMEM_REQ || bus0.oVALID) &&
                           ($urandom_range(0, 19) == 0);
      bus0.iBRANCH_TARGET = $urandom;
    end
    @(negedge clk);
    #1;
    bus0.iBRANCH_TAKEN = 1'b0;
    bus0.iSTALL = 1'b0;
    repeat (20) @(negedge clk);
    n = 0;
    while (!wrapDone && n < 100) begin
      @(negedge clk);
      n++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
